// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: state encoding, default width,
// common fp16 constants and a counter-width helper.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 16;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  // A zero-latency MAC still needs a one-bit counter so the port is legal.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Bundle of the sequencer's control, operand, MAC and result signals.
// slave = sequencer view, master = operand/result/MAC side view.
interface mac_dot_seq_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] init;
  logic             busy;

  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ready;

  logic [WIDTH-1:0] mac_a;
  logic [WIDTH-1:0] mac_b;
  logic [WIDTH-1:0] mac_c;
  logic [WIDTH-1:0] mac_out;

  logic             res_valid;
  logic [WIDTH-1:0] res;
  logic             res_ready;

  modport slave (
    input  start, len, init, in_valid, in_a, in_b, mac_out, res_ready,
    output busy, in_ready, mac_a, mac_b, mac_c, res_valid, res
  );

  modport master (
    output start, len, init, in_valid, in_a, in_b, mac_out, res_ready,
    input  busy, in_ready, mac_a, mac_b, mac_c, res_valid, res
  );

endinterface

// File: rtl/mac_wait_timer.sv
// Loadable down-counter that times the MAC latency; zero means the result
// at mac_out is valid this cycle.
module mac_wait_timer
  import mac_pkg::*;
#(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(MAX);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: feeds (a, b, acc) to an external fp16 MAC, waits its
// latency, folds mac_out back into acc and returns the final sum.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mac_dot_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] mac_a_q, mac_a_d;
  logic [WIDTH-1:0] mac_b_q, mac_b_d;
  logic [WIDTH-1:0] mac_c_q, mac_c_d;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  mac_wait_timer #(
    .MAX (MAC_LAT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    res_d       = res_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            remaining_d = bus.len;
            acc_d       = bus.init;
            state_d     = FETCH;
          end else begin
            // Empty product: the initial value is the answer, MAC untouched.
            res_d   = bus.init;
            state_d = DONE;
          end
        end
      end

      FETCH: begin
        if (bus.in_valid) begin
          mac_a_d  = bus.in_a;
          mac_b_d  = bus.in_b;
          mac_c_d  = acc_q;
          tmr_load = 1'b1;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          acc_d       = bus.mac_out;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            res_d   = bus.mac_out;
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      res_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      res_q       <= res_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = (state_q == FETCH);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_c     = mac_c_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Randomized self-checking bench for mac_dot_seq with a behavioural fp16 MAC
// (one register stage) and a fold-style dot-product reference.
module tb_mac_dot_seq;

  localparam int WIDTH   = 16;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_dot_seq_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  mac_dot_seq #(
    .WIDTH   (WIDTH),
    .LEN_W   (LEN_W),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] pa [0:255];
  logic [15:0] pb [0:255];

  // ---------------- fp16 reference arithmetic ----------------
  function automatic real p2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic int rne(input real q);
    int  f;
    real fr;
    f  = $rtoi(q);
    fr = q - real'(f);
    if (fr > 0.5) f = f + 1;
    else if ((fr == 0.5) && (f % 2 == 1)) f = f + 1;
    return f;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m, v;
    e = int'(h[14:10]);
    m = real'(h[9:0]);
    if (e == 0)       v = m * p2(-24);
    else if (e == 31) v = 1.0e30;
    else              v = (m + 1024.0) * p2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    real  a;
    int   ex, mant;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a == 0.0) return 16'h0000;
    if (a >= 65520.0) return {s, 15'h7C00};
    if (a < p2(-14)) begin
      mant = rne(a * p2(24));
      return {s, 15'(mant)};
    end
    ex = -14;
    while (a >= p2(ex + 1)) ex = ex + 1;
    mant = rne(a * p2(10 - ex));
    if (mant == 2048) begin
      mant = 1024;
      ex   = ex + 1;
    end
    if (ex > 15) return {s, 15'h7C00};
    return {s, 5'(ex + 15), 10'(mant - 1024)};
  endfunction

  function automatic logic [15:0] fma16(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    return r2h(h2r(a) * h2r(b) + h2r(c));
  endfunction

  function automatic logic [15:0] rnd_h(input int emin, input int emax);
    logic [4:0] e;
    logic [9:0] m;
    logic       s;
    s = 1'($urandom_range(0, 1));
    e = 5'($urandom_range(emin, emax));
    m = 10'($urandom);
    return {s, e, m};
  endfunction

  // Behavioural MAC with a single register stage.
  logic [15:0] mac_out_q = 16'h0000;
  always @(posedge clk) mac_out_q <= fma16(bus.mac_a, bus.mac_b, bus.mac_c);
  assign bus.mac_out = mac_out_q;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one dot product from IDLE; returns the result the bench expects.
  task automatic run_dot(input int n, input logic [15:0] init_v, input int gap,
                         input int hold, input bit poke, output logic [15:0] exp_res);
    logic [15:0] acc;
    logic [15:0] prev_a, held;
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    bus.init  = init_v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '0;
    bus.init  = 16'hFFFF;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    acc = init_v;
    for (int i = 0; i < n; i++) begin
      chk("in_ready_fetch", 32'(bus.in_ready), 32'd1);
      for (int g = 0; g < gap; g++) begin
        prev_a = bus.mac_a;
        if (poke && g == 0) begin
          bus.start = 1'b1;
          bus.len   = LEN_W'(n + 3);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("gap_no_issue", 32'(bus.in_ready), 32'd1);
        chk("gap_mac_a_hold", 32'(bus.mac_a), 32'(prev_a));
      end
      bus.in_valid = 1'b1;
      bus.in_a     = pa[i];
      bus.in_b     = pb[i];
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("mac_a", 32'(bus.mac_a), 32'(pa[i]));
      chk("mac_b", 32'(bus.mac_b), 32'(pb[i]));
      chk("mac_c", 32'(bus.mac_c), 32'(acc));
      acc = fma16(pa[i], pb[i], acc);
      cyc = 0;
      while (!(bus.in_ready || bus.res_valid) && cyc < 50) begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
      end
      chk("term_latency", 32'(cyc), 32'(MAC_LAT + 1));
      @(negedge clk);
    end
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    chk("res", 32'(bus.res), 32'(acc));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    held = bus.res;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_res", 32'(bus.res), 32'(held));
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
    exp_res = acc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    int n;
    bus.start = 1'b0; bus.len = '0; bus.init = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.res_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_mac_c", 32'(bus.mac_c), 32'd0);
    rst = 1'b0;

    // 1*2 + 3*4 from zero = 14.0
    pa[0] = 16'h3C00; pb[0] = 16'h4000;
    pa[1] = 16'h4200; pb[1] = 16'h4400;
    run_dot(2, 16'h0000, 0, 0, 1'b0, r);
    chk("dot2_const", 32'(r), 32'h4B00);

    pa[0] = 16'hCCCD; pb[0] = 16'h2936;
    run_dot(1, 16'hB396, 0, 1, 1'b0, r);

    // Empty product returns init without touching the MAC
    run_dot(0, 16'h3C00, 0, 2, 1'b0, r);
    chk("len0_const", 32'(r), 32'h3C00);

    // Backpressure on both sides, with stray start pulses while busy
    for (int i = 0; i < 4; i++) begin pa[i] = rnd_h(10, 20); pb[i] = rnd_h(10, 20); end
    run_dot(4, rnd_h(10, 20), 3, 5, 1'b1, r);

    // Reset during WAIT of term 2
    pa[0] = 16'h3C00; pb[0] = 16'h3C00;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd3; bus.init = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (!bus.in_ready && n < 20) begin @(negedge clk); n = n + 1; end
      chk("rst_seq_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.in_a = 16'h3C00; bus.in_b = 16'h3C00;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_mac_a", 32'(bus.mac_a), 32'd0);
    chk("abort_mac_c", 32'(bus.mac_c), 32'd0);
    chk("abort_res", 32'(bus.res), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized dot products
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin pa[i] = rnd_h(10, 20); pb[i] = rnd_h(10, 20); end
      run_dot(n, rnd_h(8, 20), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, r);
    end

    // Maximum term count with small operands
    for (int i = 0; i < 255; i++) begin pa[i] = rnd_h(5, 10); pb[i] = rnd_h(5, 10); end
    run_dot(255, 16'h3C00, 0, 0, 1'b0, r);

    // start coinciding with DONE->IDLE must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd0; bus.init = 16'h1234;
    @(negedge clk);
    chk("coinc_done", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1; bus.start = 1'b1; bus.len = 8'd1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0; bus.start = 1'b0;
    chk("coinc_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("coinc_stay_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
